// File: rtl/uart_rx_if.sv
// Receive-side bus between the UART engine and the bridge protocol logic.
// The slave side is the receiver; the master side drives the line, tick and read strobe.
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic                 serial_in;
  logic                 sample_tick;
  logic                 data_read;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 busy;

  modport slave (
    input  serial_in, sample_tick, data_read,
    output data_out, data_ready, framing_error, overrun_error, busy
  );

  modport master (
    output serial_in, sample_tick, data_read,
    input  data_out, data_ready, framing_error, overrun_error, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start detection, mid-bit sampling,
// ready/read handoff with sticky framing and overrun flags.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      clock,
  input  logic      reset,
  uart_rx_if.slave  bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               r_state, w_nxt;
  logic [1:0]           r_sync;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_ready, r_ferr, r_oerr;
  logic                 w_rx_s, w_tick_clr, w_tick_inc, w_bit_clr, w_shift, w_load, w_ferr_set;

  always_ff @(posedge clock or posedge reset)
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], bus.serial_in};

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;

  always_comb begin
    w_nxt      = r_state;
    w_tick_clr = 1'b0;
    w_tick_inc = 1'b0;
    w_bit_clr  = 1'b0;
    w_shift    = 1'b0;
    w_load     = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      IDLE:
        if (bus.sample_tick && !w_rx_s) begin
          w_nxt      = START;
          w_tick_clr = 1'b1;
        end
      START:
        if (bus.sample_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE/2 - 1)) begin
            // Mid start bit: a high line here means a glitch, not a frame.
            w_nxt      = w_rx_s ? IDLE : DATA;
            w_tick_clr = 1'b1;
            w_bit_clr  = 1'b1;
          end else w_tick_inc = 1'b1;
        end
      DATA:
        if (bus.sample_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            w_shift    = 1'b1;
            w_tick_clr = 1'b1;
            if (r_bit_cnt == BW'(DATA_BITS - 1)) w_nxt = STOP;
          end else w_tick_inc = 1'b1;
        end
      STOP:
        if (bus.sample_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            w_tick_clr = 1'b1;
            if (w_rx_s) begin
              w_load = 1'b1;
              w_nxt  = IDLE;
            end else begin
              w_ferr_set = 1'b1;
              w_nxt      = WAIT_IDLE;
            end
          end else w_tick_inc = 1'b1;
        end
      WAIT_IDLE:
        if (w_rx_s) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_ferr     <= 1'b0;
      r_oerr     <= 1'b0;
    end else begin
      if (w_tick_clr)      r_tick_cnt <= '0;
      else if (w_tick_inc) r_tick_cnt <= r_tick_cnt + TW'(1);
      if (w_bit_clr)       r_bit_cnt  <= '0;
      else if (w_shift)    r_bit_cnt  <= r_bit_cnt + BW'(1);
      if (w_shift)         r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      if (w_load)          r_data     <= r_shift;
      // A load coincident with a read keeps the byte available.
      if (w_load)              r_ready <= 1'b1;
      else if (bus.data_read)  r_ready <= 1'b0;
      if (w_ferr_set)          r_ferr  <= 1'b1;
      else if (bus.data_read)  r_ferr  <= 1'b0;
      if (w_load && r_ready && !bus.data_read) r_oerr <= 1'b1;
      else if (bus.data_read)                  r_oerr <= 1'b0;
    end

  assign bus.data_out      = r_data;
  assign bus.data_ready    = r_ready;
  assign bus.framing_error = r_ferr;
  assign bus.overrun_error = r_oerr;
  assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, expected bytes queued at send time and
// checked by an independent monitor whenever a new byte is presented.
module tb_uart_rx;
  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) bus();

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       oe;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One sample_tick every 4 clocks, changed just after a rising edge.
  initial begin
    bus.sample_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clock);
      #1 bus.sample_tick = 1'b1;
      @(posedge clock);
      #1 bus.sample_tick = 1'b0;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clock); while (bus.sample_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic pulse_read();
    @(posedge clock);
    #1 bus.data_read = 1'b1;
    @(posedge clock);
    #1 bus.data_read = 1'b0;
  endtask

  // Stop bit is sampled on the 153rd tick after the start edge is driven;
  // rd_stop lands a one-cycle read exactly on that tick.
  task automatic send(input logic [7:0] d, input logic stop_v, input logic rd_stop);
    logic [9:0] fr;
    fr = {stop_v, d, 1'b0};
    wait_ticks(1);
    for (int b = 0; b < 10; b++) begin
      bus.serial_in = fr[b];
      if (b == 9 && rd_stop) begin
        wait_ticks(8);
        repeat (3) @(posedge clock);
        #1 bus.data_read = 1'b1;
        @(posedge clock);
        #1 bus.data_read = 1'b0;
        wait_ticks(7);
      end else wait_ticks(16);
    end
  endtask

  // Monitor: a new byte is a rising data_ready or a changed data_out while ready.
  initial begin
    logic       pr;
    logic [7:0] po;
    exp_t       e;
    pr = 1'b0;
    po = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset && bus.data_ready && (!pr || bus.data_out != po)) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.data_out);
        end else begin
          e = q.pop_front();
          chk("byte_data", 32'(bus.data_out), 32'(e.d));
          chk("byte_overrun", 32'(bus.overrun_error), 32'(e.oe));
          chk("byte_framing", 32'(bus.framing_error), 32'(e.fe));
        end
      end
      pr = bus.data_ready;
      po = bus.data_out;
    end
  end

  initial begin
    logic [7:0] bb [3];
    logic [7:0] c3;
    bb = '{8'h00, 8'hFF, 8'h3C};
    c3 = 8'hC3;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_ready", 32'(bus.data_ready), 32'h0);
    chk("rst_ferr", 32'(bus.framing_error), 32'h0);
    chk("rst_oerr", 32'(bus.overrun_error), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    wait_ticks(4);

    // normal frame
    q.push_back('{d: 8'hA5, fe: 1'b0, oe: 1'b0});
    send(8'hA5, 1'b1, 1'b0);
    chk("a5_ready", 32'(bus.data_ready), 32'h1);
    pulse_read();
    chk("a5_ready_clr", 32'(bus.data_ready), 32'h0);

    // back-to-back
    for (int i = 0; i < 3; i++) begin
      q.push_back('{d: bb[i], fe: 1'b0, oe: 1'b0});
      send(bb[i], 1'b1, 1'b0);
      chk("b2b_busy_gap", 32'(bus.busy), 32'h0);
      pulse_read();
      chk("b2b_oerr", 32'(bus.overrun_error), 32'h0);
    end

    // false start
    wait_ticks(1);
    bus.serial_in = 1'b0;
    wait_ticks(4);
    chk("fs_busy_during", 32'(bus.busy), 32'h1);
    bus.serial_in = 1'b1;
    wait_ticks(16);
    chk("fs_busy_after", 32'(bus.busy), 32'h0);
    chk("fs_ready", 32'(bus.data_ready), 32'h0);
    chk("fs_ferr", 32'(bus.framing_error), 32'h0);
    q.push_back('{d: 8'h5A, fe: 1'b0, oe: 1'b0});
    send(8'h5A, 1'b1, 1'b0);
    pulse_read();

    // framing error, line held low (break)
    send(8'h81, 1'b0, 1'b0);
    wait_ticks(16);
    chk("fe_flag", 32'(bus.framing_error), 32'h1);
    chk("fe_ready", 32'(bus.data_ready), 32'h0);
    chk("fe_busy_break", 32'(bus.busy), 32'h1);
    bus.serial_in = 1'b1;
    wait_ticks(2);
    chk("fe_busy_idle", 32'(bus.busy), 32'h0);
    pulse_read();
    chk("fe_clr", 32'(bus.framing_error), 32'h0);
    q.push_back('{d: 8'h42, fe: 1'b0, oe: 1'b0});
    send(8'h42, 1'b1, 1'b0);
    pulse_read();

    // overrun, then read coincident with the second load
    q.push_back('{d: 8'h11, fe: 1'b0, oe: 1'b0});
    send(8'h11, 1'b1, 1'b0);
    q.push_back('{d: 8'h22, fe: 1'b0, oe: 1'b1});
    send(8'h22, 1'b1, 1'b0);
    chk("ovr_flag", 32'(bus.overrun_error), 32'h1);
    chk("ovr_data", 32'(bus.data_out), 32'h22);
    pulse_read();
    chk("ovr_ready_clr", 32'(bus.data_ready), 32'h0);
    chk("ovr_flag_clr", 32'(bus.overrun_error), 32'h0);
    q.push_back('{d: 8'h33, fe: 1'b0, oe: 1'b0});
    send(8'h33, 1'b1, 1'b0);
    q.push_back('{d: 8'h44, fe: 1'b0, oe: 1'b0});
    send(8'h44, 1'b1, 1'b1);
    chk("coinc_ready", 32'(bus.data_ready), 32'h1);
    chk("coinc_oerr", 32'(bus.overrun_error), 32'h0);
    chk("coinc_data", 32'(bus.data_out), 32'h44);

    // reset during data bit 4 of 0xC3
    wait_ticks(1);
    bus.serial_in = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 4; b++) begin
      bus.serial_in = c3[b];
      wait_ticks(16);
    end
    bus.serial_in = c3[4];
    wait_ticks(8);
    chk("mid_busy", 32'(bus.busy), 32'h1);
    bus.serial_in = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_data", 32'(bus.data_out), 32'h0);
    chk("mid_rst_ready", 32'(bus.data_ready), 32'h0);
    chk("mid_rst_ferr", 32'(bus.framing_error), 32'h0);
    chk("mid_rst_oerr", 32'(bus.overrun_error), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    wait_ticks(20);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    q.push_back('{d: 8'h99, fe: 1'b0, oe: 1'b0});
    send(8'h99, 1'b1, 1'b0);
    pulse_read();

    repeat (10) @(posedge clock);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
